// File: rtl/inst_queue.sv
// Instruction queue between IF and ID: circular FIFO of fetched instructions with predictor info.
// Latency: an entry pushed in cycle N reaches the outputs in cycle N+1 (FWFT). With
//   INST_QUEUE_BYPASS_EN defined, a push into an empty queue shows on the outputs in the same cycle.
// Backpressure: full stops pushes (registered occupancy); stall_next_stage holds the head entry.
// Optional feature macro: INST_QUEUE_BYPASS_EN (empty-queue same-cycle bypass).

`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef INST_BUS
`define INST_BUS 31:0
`endif
`ifndef GHR_BUS
`define GHR_BUS 7:0
`endif

module inst_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     stall_next_stage,
  input  logic                     write_en,
  input  logic [`ADDR_BUS]         pc_in,
  input  logic [`INST_BUS]         inst_in,
  input  logic                     is_branch_taken_in,
  input  logic [`GHR_BUS]          pht_index_in,
  output logic                     full,
  output logic                     valid_out,
  output logic [`ADDR_BUS]         pc_out,
  output logic [`INST_BUS]         inst_out,
  output logic                     is_branch_taken_out,
  output logic [`GHR_BUS]          pht_index_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

  // One queued instruction together with its branch-prediction side data.
  typedef struct packed {
    logic [`ADDR_BUS] pc;
    logic [`INST_BUS] inst;
    logic             br_taken;
    logic [`GHR_BUS]  pht_idx;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [AW:0]     r_count;

  entry_t          w_in;
  entry_t          w_out;
  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;

  assign w_in.pc       = pc_in;
  assign w_in.inst     = inst_in;
  assign w_in.br_taken = is_branch_taken_in;
  assign w_in.pht_idx  = pht_index_in;

  // Full/empty come from the registered occupancy only, so a pop in the same
  // cycle never makes room for a push.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

  // Push/pop decisions and the head-entry presentation (zeros when empty = NOP bubble).
  always_comb begin
    w_push    = write_en && !w_full;
    w_pop     = !w_empty && !stall_next_stage;
    valid_out = !w_empty;
    w_out     = w_empty ? '0 : r_mem[r_head];
`ifdef INST_QUEUE_BYPASS_EN
    // Empty queue: hand the incoming entry straight to ID. If ID takes it this
    // cycle it is never stored; if ID stalls it is stored as a normal push.
    if (w_empty && !flush && write_en) begin
      valid_out = 1'b1;
      w_out     = w_in;
      if (!stall_next_stage) begin
        w_push = 1'b0;
      end
    end
`endif
  end

  // Pointer and occupancy state; flush wins over push/pop and re-aligns both pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_ONE;
      end
      if (w_pop) begin
        r_head <= r_head + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are not reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_tail] <= w_in;
    end
  end

  assign full                = w_full;
  assign count               = r_count;
  assign pc_out              = w_out.pc;
  assign inst_out            = w_out.inst;
  assign is_branch_taken_out = w_out.br_taken;
  assign pht_index_out       = w_out.pht_idx;

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of entries; it is a power of two and at least 2.
REQ-002 SHALL have ports clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, the reset; asynchronous, active-high.
REQ-004 SHALL have port flush, input, 1 bit, which discards all queued entries.
REQ-005 SHALL have port stall_next_stage, input, 1 bit: ID cannot accept an instruction this cycle.
REQ-006 SHALL have port write_en, input, 1 bit, the IF push request.
REQ-007 SHALL have port pc_in, input, `ADDR_BUS, the fetched PC.
REQ-008 SHALL have port inst_in, input, `INST_BUS, the fetched instruction.
REQ-009 SHALL have port is_branch_taken_in, input, 1 bit, the predictor decision.
REQ-010 SHALL have port pht_index_in, input, `GHR_BUS, the predictor PHT index.
REQ-011 SHALL have port full, output, 1 bit, meaning occupancy == DEPTH.
REQ-012 SHALL have port valid_out, output, 1 bit, meaning the head entry is presented to ID.
REQ-013 SHALL have ports pc_out, inst_out, is_branch_taken_out and pht_index_out, outputs, widths as the matching inputs, carrying the head entry to ID pc_in/inst_in/is_branch_taken_in/pht_index_in.
REQ-014 SHALL have port count, output, log2(DEPTH)+1 bits, the current occupancy.

Function
REQ-015 SHALL implement a circular FIFO with head/tail pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-016 SHALL accept a push when write_en=1 and full=0; write_en while full is ignored with no state change.
REQ-017 SHALL evaluate full from the registered occupancy, so a push while full is rejected even when a pop occurs in the same cycle.
REQ-018 SHALL pop when valid_out=1 and stall_next_stage=0.
REQ-019 SHALL, on a simultaneous push and pop, advance both pointers and leave count unchanged.
REQ-020 SHALL present the head entry combinationally (first-word fall-through); an entry pushed in cycle N is visible on the outputs in cycle N+1.
REQ-021 SHALL, when empty, drive valid_out=0 and pc_out, inst_out, is_branch_taken_out and pht_index_out all 0, so ID sees a NOP bubble.
REQ-022 SHALL, when flush=1, set count to 0 and equalize the pointers at the next edge; flush has priority over push and pop in that cycle.
REQ-023 SHALL preserve entry order exactly; no entry is duplicated or dropped except by flush.

Reset
REQ-024 SHALL, while rst=1, asynchronously clear head, tail and count, giving full=0, valid_out=0 and all data outputs 0.
REQ-025 SHALL abandon a push or pop in flight when reset asserts mid-operation; storage contents need not be cleared.

Configuration
REQ-026 SHALL support the macro INST_QUEUE_BYPASS_EN.
- Defined: when the queue is empty, flush=0 and write_en=1, outputs show the inputs in the same cycle with valid_out=1.
- Defined: if stall_next_stage=0 in that cycle, the entry is consumed and not stored; if stalled, it is stored normally.
- Undefined: the REQ-020 one-cycle latency applies unconditionally.

Verification
REQ-027 Reset, then push pc=32'hbfc00000, inst=32'h90001234 with no stall -> next cycle valid_out=1, pc_out=32'hbfc00000, inst_out=32'h90001234; after the pop, valid_out=0 and all outputs 0 (without bypass).
REQ-028 With stall_next_stage=1, push 9 entries (pc 32'hbfc00000 + 4*i, DEPTH=8) -> full=1 after the 8th, 9th ignored, count=8; release stall -> 8 entries out in order, last pc=32'hbfc0001c.
REQ-029 Fill to count=8, then drive write_en=1 with stall=0 for one cycle -> push rejected, count=7; continue to drain and refill across the wrap point -> order preserved.
REQ-030 Queue at count=3, assert flush together with write_en=1 -> next cycle count=0, valid_out=0; the pushed entry is not present.
REQ-031 Assert rst asynchronously mid-burst at count=5 -> count=0, valid_out=0 and full=0 immediately, before the next clock edge.
REQ-032 With INST_QUEUE_BYPASS_EN, empty queue, push inst=32'hac001234 with stall=0 -> same cycle valid_out=1, inst_out=32'hac001234; next cycle count=0.
